// File: rtl/cok_cevrim_denetleyici_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cok_cevrim_denetleyici_pkg
// Purpose : Shared state encoding, defaults and unit opcodes for the
//           multi-cycle unit sequencer.
// Rev     : 1.0
// ============================================================================
package cok_cevrim_denetleyici_pkg;

  typedef enum logic [1:0] {
    CC_BOS   = 2'd0,
    CC_BEKLE = 2'd1,
    CC_IPTAL = 2'd2,
    CC_SONUC = 2'd3
  } cc_durum_t;

  localparam int CC_ZAMAN_ASIMI_VARSAYILAN = 64;

  localparam logic [3:0] CC_KOD_DIV    = 4'h0;
  localparam logic [3:0] CC_KOD_REM    = 4'h1;
  localparam logic [3:0] CC_KOD_AI_MAC = 4'h8;

  // Cycle counter width; one bit minimum so the smallest legal timeout works.
  function automatic int cc_sayac_bit(input int zaman_asimi);
    return (zaman_asimi > 2) ? $clog2(zaman_asimi) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cok_cevrim_denetleyici_son_sonuc_tamponu.sv
`default_nettype none
// ============================================================================
// Module  : cc_son_sonuc_tamponu
// Purpose : Single-entry last-result buffer: stores {kod, islec1, islec2,
//           sonuc} and reports a hit for an identical new request.
// Rev     : 1.0
// ============================================================================
module cc_son_sonuc_tamponu #(
  parameter int VERI_BIT  = 32,
  parameter int ISLEM_BIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 yaz_i,
  input  logic                 temizle_i,
  input  logic [ISLEM_BIT-1:0] kod_i,
  input  logic [VERI_BIT-1:0]  islec1_i,
  input  logic [VERI_BIT-1:0]  islec2_i,
  input  logic [VERI_BIT-1:0]  sonuc_i,
  input  logic [ISLEM_BIT-1:0] sorgu_kod_i,
  input  logic [VERI_BIT-1:0]  sorgu_islec1_i,
  input  logic [VERI_BIT-1:0]  sorgu_islec2_i,
  output logic                 isabet_o,
  output logic [VERI_BIT-1:0]  sonuc_o
);

  logic                 r_gecerli;
  logic [ISLEM_BIT-1:0] r_kod;
  logic [VERI_BIT-1:0]  r_islec1;
  logic [VERI_BIT-1:0]  r_islec2;
  logic [VERI_BIT-1:0]  r_sonuc;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_gecerli <= 1'b0;
      r_kod     <= '0;
      r_islec1  <= '0;
      r_islec2  <= '0;
      r_sonuc   <= '0;
    end else if (temizle_i) begin
      r_gecerli <= 1'b0;
    end else if (yaz_i) begin
      r_gecerli <= 1'b1;
      r_kod     <= kod_i;
      r_islec1  <= islec1_i;
      r_islec2  <= islec2_i;
      r_sonuc   <= sonuc_i;
    end
  end

  assign isabet_o = r_gecerli && (r_kod == sorgu_kod_i) &&
                    (r_islec1 == sorgu_islec1_i) && (r_islec2 == sorgu_islec2_i);
  assign sonuc_o  = r_sonuc;

endmodule
`default_nettype wire

// File: rtl/cok_cevrim_denetleyici.sv
`default_nettype none
// ============================================================================
// Module  : cok_cevrim_denetleyici
// Purpose : Sequences a long-latency execute-stage unit: latch, start pulse,
//           stall, result hold, flush drain and timeout.
//           COK_CEVRIM_SON_SONUC_EN adds a last-result bypass buffer.
// Rev     : 1.0
// ============================================================================
module cok_cevrim_denetleyici
  import cok_cevrim_denetleyici_pkg::*;
#(
  parameter int VERI_BIT    = 32,
  parameter int ISLEM_BIT   = 4,
  parameter int ETIKET_BIT  = 4,
  parameter int ZAMAN_ASIMI = CC_ZAMAN_ASIMI_VARSAYILAN
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  istek_gecerli_i,
  input  logic [ISLEM_BIT-1:0]  istek_kod_i,
  input  logic [VERI_BIT-1:0]   istek_islec1_i,
  input  logic [VERI_BIT-1:0]   istek_islec2_i,
  input  logic [ETIKET_BIT-1:0] istek_etiket_i,
  input  logic                  bosalt_i,
  input  logic                  cek_duraklat_i,
  output logic                  duraklat_o,
  output logic                  birim_basla_o,
  output logic [ISLEM_BIT-1:0]  birim_kod_o,
  output logic [VERI_BIT-1:0]   birim_islec1_o,
  output logic [VERI_BIT-1:0]   birim_islec2_o,
  input  logic [VERI_BIT-1:0]   birim_sonuc_i,
  input  logic                  birim_gecerli_i,
  output logic [VERI_BIT-1:0]   sonuc_o,
  output logic [ETIKET_BIT-1:0] sonuc_etiket_o,
  output logic                  sonuc_gecerli_o,
  output logic                  hata_o
);

  localparam int                  c_sayac_bit = cc_sayac_bit(ZAMAN_ASIMI);
  localparam logic [c_sayac_bit-1:0] c_sayac_son = c_sayac_bit'(ZAMAN_ASIMI - 1);

  cc_durum_t             r_durum;
  logic [c_sayac_bit-1:0] r_sayac;
  logic [ETIKET_BIT-1:0] r_etiket;

  logic                  w_zaman_doldu;
  logic                  w_isabet;
  logic [VERI_BIT-1:0]   w_tampon_sonuc;

  assign w_zaman_doldu = (r_sayac == c_sayac_son);
  assign duraklat_o    = istek_gecerli_i && (r_durum != CC_SONUC);

`ifdef COK_CEVRIM_SON_SONUC_EN
  logic w_tampon_yaz;
  logic w_tampon_temizle;

  assign w_tampon_yaz     = (r_durum == CC_BEKLE) && !bosalt_i && birim_gecerli_i;
  assign w_tampon_temizle = ((r_durum == CC_BEKLE) || (r_durum == CC_IPTAL)) &&
                            w_zaman_doldu && !birim_gecerli_i;

  cc_son_sonuc_tamponu #(
    .VERI_BIT  (VERI_BIT),
    .ISLEM_BIT (ISLEM_BIT)
  ) u_son_sonuc (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .yaz_i          (w_tampon_yaz),
    .temizle_i      (w_tampon_temizle),
    .kod_i          (birim_kod_o),
    .islec1_i       (birim_islec1_o),
    .islec2_i       (birim_islec2_o),
    .sonuc_i        (birim_sonuc_i),
    .sorgu_kod_i    (istek_kod_i),
    .sorgu_islec1_i (istek_islec1_i),
    .sorgu_islec2_i (istek_islec2_i),
    .isabet_o       (w_isabet),
    .sonuc_o        (w_tampon_sonuc)
  );
`else
  assign w_isabet       = 1'b0;
  assign w_tampon_sonuc = '0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_durum         <= CC_BOS;
      r_sayac         <= '0;
      r_etiket        <= '0;
      birim_basla_o   <= 1'b0;
      birim_kod_o     <= '0;
      birim_islec1_o  <= '0;
      birim_islec2_o  <= '0;
      sonuc_o         <= '0;
      sonuc_etiket_o  <= '0;
      sonuc_gecerli_o <= 1'b0;
      hata_o          <= 1'b0;
    end else begin
      birim_basla_o <= 1'b0;
      case (r_durum)
        CC_BOS: begin
          if (istek_gecerli_i && !bosalt_i) begin
            birim_kod_o    <= istek_kod_i;
            birim_islec1_o <= istek_islec1_i;
            birim_islec2_o <= istek_islec2_i;
            r_etiket       <= istek_etiket_i;
            if (w_isabet) begin
              sonuc_o         <= w_tampon_sonuc;
              sonuc_etiket_o  <= istek_etiket_i;
              hata_o          <= 1'b0;
              sonuc_gecerli_o <= 1'b1;
              r_durum         <= CC_SONUC;
            end else begin
              birim_basla_o <= 1'b1;
              r_sayac       <= '0;
              r_durum       <= CC_BEKLE;
            end
          end
        end
        CC_BEKLE: begin
          r_sayac <= r_sayac + 1'b1;
          // A flush that coincides with the unit finishing needs no drain.
          if (bosalt_i) begin
            r_durum <= (birim_gecerli_i || w_zaman_doldu) ? CC_BOS : CC_IPTAL;
          end else if (birim_gecerli_i) begin
            sonuc_o         <= birim_sonuc_i;
            sonuc_etiket_o  <= r_etiket;
            hata_o          <= 1'b0;
            sonuc_gecerli_o <= 1'b1;
            r_durum         <= CC_SONUC;
          end else if (w_zaman_doldu) begin
            sonuc_o         <= '0;
            sonuc_etiket_o  <= r_etiket;
            hata_o          <= 1'b1;
            sonuc_gecerli_o <= 1'b1;
            r_durum         <= CC_SONUC;
          end
        end
        CC_IPTAL: begin
          r_sayac <= r_sayac + 1'b1;
          if (birim_gecerli_i || w_zaman_doldu) begin
            r_durum <= CC_BOS;
          end
        end
        CC_SONUC: begin
          if (bosalt_i || !cek_duraklat_i) begin
            sonuc_gecerli_o <= 1'b0;
            r_durum         <= CC_BOS;
          end
        end
        default: r_durum <= CC_BOS;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cok_cevrim_denetleyici.sv
`default_nettype none
// ============================================================================
// Module  : tb_cok_cevrim_denetleyici
// Purpose : Self-checking bench: timing tables, corner sequences and a
//           randomized run against a transaction-level reference model.
// Rev     : 1.0
// ============================================================================
module tb_cok_cevrim_denetleyici;

  localparam int ZA = 16;

  typedef struct packed {
    logic        istek;
    logic [3:0]  kod;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic        bosalt;
    logic        cek;
    logic        bgec;
    logic [31:0] bsonuc;
  } girdi_t;

  typedef struct packed {
    girdi_t      g;
    logic        dur;
    logic        basla;
    logic        gec;
    logic [31:0] sonuc;
    logic [3:0]  etk;
    logic        hata;
  } vektor_t;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        istek_gecerli_i, bosalt_i, cek_duraklat_i, birim_gecerli_i;
  logic [3:0]  istek_kod_i, istek_etiket_i;
  logic [31:0] istek_islec1_i, istek_islec2_i, birim_sonuc_i;
  logic        duraklat_o, birim_basla_o, sonuc_gecerli_o, hata_o;
  logic [3:0]  birim_kod_o, sonuc_etiket_o;
  logic [31:0] birim_islec1_o, birim_islec2_o, sonuc_o;

  cok_cevrim_denetleyici #(
    .VERI_BIT(32), .ISLEM_BIT(4), .ETIKET_BIT(4), .ZAMAN_ASIMI(ZA)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .istek_gecerli_i(istek_gecerli_i), .istek_kod_i(istek_kod_i),
    .istek_islec1_i(istek_islec1_i), .istek_islec2_i(istek_islec2_i),
    .istek_etiket_i(istek_etiket_i), .bosalt_i(bosalt_i),
    .cek_duraklat_i(cek_duraklat_i), .duraklat_o(duraklat_o),
    .birim_basla_o(birim_basla_o), .birim_kod_o(birim_kod_o),
    .birim_islec1_o(birim_islec1_o), .birim_islec2_o(birim_islec2_o),
    .birim_sonuc_i(birim_sonuc_i), .birim_gecerli_i(birim_gecerli_i),
    .sonuc_o(sonuc_o), .sonuc_etiket_o(sonuc_etiket_o),
    .sonuc_gecerli_o(sonuc_gecerli_o), .hata_o(hata_o)
  );

  always #5 clk_i = ~clk_i;

  int n_toplam = 0;
  int n_gecti  = 0;

  task automatic kontrol(input string ad, input logic [31:0] got, input logic [31:0] exp);
    n_toplam++;
    if (got === exp) n_gecti++;
    else $display("FAIL %s: got %0h expected %0h", ad, got, exp);
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          m_mesgul, m_iptal, m_ilk, m_tut, m_hata;
  int          m_yas;
  logic [3:0]  m_kod, m_etk, m_setk;
  logic [31:0] m_a, m_b, m_son;
  bit          t_gec;
  logic [3:0]  t_kod;
  logic [31:0] t_a, t_b, t_son;
  girdi_t      r_g;

  function automatic void model_sifirla();
    m_mesgul = 0; m_iptal = 0; m_ilk = 0; m_tut = 0; m_hata = 0; m_yas = 0;
    m_kod = '0; m_etk = '0; m_setk = '0; m_a = '0; m_b = '0; m_son = '0;
    t_gec = 0; t_kod = '0; t_a = '0; t_b = '0; t_son = '0;
  endfunction

  function automatic bit tampon_isabet(input girdi_t g);
`ifdef COK_CEVRIM_SON_SONUC_EN
    return t_gec && t_kod == g.kod && t_a == g.a && t_b == g.b;
`else
    return (g.kod === 4'hx);
`endif
  endfunction

  function automatic void teslim(input logic [31:0] s, input logic [3:0] e, input bit h);
    m_tut = 1; m_son = s; m_setk = e; m_hata = h;
  endfunction

  function automatic void model_adim();
    bit son;
    if (!rstn_i) begin model_sifirla(); return; end
    m_ilk = 0;
    if (m_tut) begin
      if (r_g.bosalt || !r_g.cek) m_tut = 0;
    end else if (m_mesgul) begin
      son = (m_yas == ZA - 1);
      if (son && !r_g.bgec) t_gec = 0;
      if (m_iptal || r_g.bosalt) begin
        if (r_g.bgec || son) m_mesgul = 0;
        else begin m_iptal = 1; m_yas++; end
      end else if (r_g.bgec) begin
        teslim(r_g.bsonuc, m_etk, 0);
        m_mesgul = 0;
        t_gec = 1; t_kod = m_kod; t_a = m_a; t_b = m_b; t_son = r_g.bsonuc;
      end else if (son) begin
        teslim('0, m_etk, 1);
        m_mesgul = 0;
      end else m_yas++;
    end else if (r_g.istek && !r_g.bosalt) begin
      m_kod = r_g.kod; m_a = r_g.a; m_b = r_g.b; m_etk = r_g.tag;
      if (tampon_isabet(r_g)) teslim(t_son, r_g.tag, 0);
      else begin m_mesgul = 1; m_iptal = 0; m_yas = 0; m_ilk = 1; end
    end
  endfunction

  // ---------------- cycle helpers ----------------
  task automatic sur(input girdi_t g);
    r_g = g;
    istek_gecerli_i = g.istek; istek_kod_i = g.kod;
    istek_islec1_i = g.a; istek_islec2_i = g.b; istek_etiket_i = g.tag;
    bosalt_i = g.bosalt; cek_duraklat_i = g.cek;
    birim_gecerli_i = g.bgec; birim_sonuc_i = g.bsonuc;
    #4;
    kontrol("model_duraklat", duraklat_o, g.istek && !m_tut);
    kontrol("model_basla", birim_basla_o, m_ilk);
    kontrol("model_birim_kod", birim_kod_o, m_kod);
    kontrol("model_birim_islec1", birim_islec1_o, m_a);
    kontrol("model_birim_islec2", birim_islec2_o, m_b);
    kontrol("model_gecerli", sonuc_gecerli_o, m_tut);
    if (m_tut) begin
      kontrol("model_sonuc", sonuc_o, m_son);
      kontrol("model_etiket", sonuc_etiket_o, m_setk);
      kontrol("model_hata", hata_o, m_hata);
    end
  endtask

  task automatic kenar();
    @(posedge clk_i);
    model_adim();
    #1;
  endtask

  function automatic girdi_t gy(input bit istek, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] tag);
    girdi_t g;
    g = '0;
    g.istek = istek; g.kod = 4'h0; g.a = a; g.b = b; g.tag = tag;
    return g;
  endfunction

  vektor_t tablo[$];

  // Request at cycle 0, unit valid at cycle 6, result at 7, held n extra cycles.
  function automatic void normal_tablo(input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] tag, input logic [31:0] res, input int n);
    vektor_t v;
    for (int c = 0; c <= 8 + n; c++) begin
      v = '0;
      v.g = gy(c <= 7 + n, a, b, tag);
      v.g.bgec   = (c == 6);
      v.g.bsonuc = (c == 6) ? res : 32'hDEAD_0000 + c;
      v.g.cek    = (c >= 7 && c < 7 + n);
      v.dur   = v.g.istek && (c <= 6);
      v.basla = (c == 1);
      v.gec   = (c >= 7 && c <= 7 + n);
      v.sonuc = res; v.etk = tag; v.hata = 1'b0;
      tablo.push_back(v);
    end
  endfunction

  task automatic tablo_kos(input string ad);
    foreach (tablo[i]) begin
      sur(tablo[i].g);
      kontrol({ad, "_duraklat"}, duraklat_o, tablo[i].dur);
      kontrol({ad, "_basla"}, birim_basla_o, tablo[i].basla);
      kontrol({ad, "_gecerli"}, sonuc_gecerli_o, tablo[i].gec);
      if (tablo[i].gec) begin
        kontrol({ad, "_sonuc"}, sonuc_o, tablo[i].sonuc);
        kontrol({ad, "_etiket"}, sonuc_etiket_o, tablo[i].etk);
        kontrol({ad, "_hata"}, hata_o, tablo[i].hata);
      end
      kenar();
    end
    tablo.delete();
  endtask

  initial begin
    girdi_t  g;
    vektor_t v;
    model_sifirla();
    r_g = '0;
    // reset state
    @(posedge clk_i); #1;
    sur('0);
    kontrol("reset_gecerli", sonuc_gecerli_o, 0);
    kontrol("reset_basla", birim_basla_o, 0);
    kontrol("reset_sonuc", sonuc_o, 0);
    kontrol("reset_hata", hata_o, 0);
    kontrol("reset_birim_islec1", birim_islec1_o, 0);
    rstn_i = 1'b1;
    kenar();

    // normal operation
    normal_tablo(32'd100, 32'd7, 4'd3, 32'd14, 0);
    tablo_kos("t1");

    // repeat of the same request
`ifdef COK_CEVRIM_SON_SONUC_EN
    v = '0; v.g = gy(1, 100, 7, 4'd7); v.dur = 1; tablo.push_back(v);
    v = '0; v.g = gy(1, 100, 7, 4'd7); v.gec = 1; v.sonuc = 14; v.etk = 4'd7; tablo.push_back(v);
    v = '0; v.g = gy(0, 100, 7, 4'd7); tablo.push_back(v);
`else
    normal_tablo(32'd100, 32'd7, 4'd7, 32'd14, 0);
`endif
    tablo_kos("t6");

    // downstream stall
    normal_tablo(32'd200, 32'd9, 4'd5, 32'd22, 3);
    tablo_kos("t2");

    // flush in BEKLE, new request during the drain
    for (int c = 0; c <= 11; c++) begin
      g = '0;
      if (c <= 2) g = gy(1, 50, 5, 4'd1);
      if (c == 3) g.bosalt = 1'b1;
      if (c >= 4 && c <= 10) g = gy(1, 81, 9, 4'd2);
      if (c == 6) begin g.bgec = 1'b1; g.bsonuc = 32'd10; end
      if (c == 9) begin g.bgec = 1'b1; g.bsonuc = 32'd9; end
      sur(g);
      if (c >= 4 && c <= 7) begin
        kontrol("t3_gecerli_yok", sonuc_gecerli_o, 0);
        kontrol("t3_duraklat", duraklat_o, 1);
      end
      if (c == 8) kontrol("t3_basla", birim_basla_o, 1);
      if (c == 10) begin
        kontrol("t3_gecerli", sonuc_gecerli_o, 1);
        kontrol("t3_sonuc", sonuc_o, 9);
        kontrol("t3_etiket", sonuc_etiket_o, 2);
      end
      kenar();
    end

    // timeout
    for (int c = 0; c <= 18; c++) begin
      g = gy(c <= 17, 33, 3, 4'd4);
      sur(g);
      if (c == 16) begin
        kontrol("t4_duraklat", duraklat_o, 1);
        kontrol("t4_gecerli_once", sonuc_gecerli_o, 0);
      end
      if (c == 17) begin
        kontrol("t4_gecerli", sonuc_gecerli_o, 1);
        kontrol("t4_hata", hata_o, 1);
        kontrol("t4_sonuc", sonuc_o, 0);
        kontrol("t4_etiket", sonuc_etiket_o, 4);
      end
      if (c == 18) kontrol("t4_gecerli_son", sonuc_gecerli_o, 0);
      kenar();
    end

    // asynchronous reset in BEKLE
    for (int c = 0; c <= 2; c++) begin
      sur(gy(1, 70, 7, 4'd6));
      kenar();
    end
    sur('0);
    #2 rstn_i = 1'b0;
    model_sifirla();
    #1;
    kontrol("t5_basla", birim_basla_o, 0);
    kontrol("t5_birim_kod", birim_kod_o, 0);
    kontrol("t5_birim_islec1", birim_islec1_o, 0);
    kontrol("t5_birim_islec2", birim_islec2_o, 0);
    kontrol("t5_gecerli", sonuc_gecerli_o, 0);
    kontrol("t5_sonuc", sonuc_o, 0);
    kontrol("t5_etiket", sonuc_etiket_o, 0);
    kontrol("t5_hata", hata_o, 0);
    kontrol("t5_duraklat", duraklat_o, 0);
    kenar();
    sur('0);
    rstn_i = 1'b1;
    kenar();
    normal_tablo(32'd100, 32'd7, 4'd3, 32'd14, 0);
    tablo_kos("t5_sonra");

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      g = '0;
      g.istek  = 1'($urandom_range(0, 1));
      g.kod    = 4'($urandom_range(0, 1));
      g.a      = 32'($urandom_range(1, 3));
      g.b      = 32'($urandom_range(1, 3));
      g.tag    = 4'($urandom_range(0, 15));
      g.bosalt = ($urandom_range(0, 15) == 0);
      g.cek    = ($urandom_range(0, 2) == 0);
      g.bgec   = ($urandom_range(0, 5) == 0);
      g.bsonuc = $urandom;
      sur(g);
      kenar();
    end

    $display("%0d/%0d checks passed", n_gecti, n_toplam);
    $finish;
  end

endmodule
`default_nettype wire
